// File: rtl/core_list_lookup_if.sv
// -----------------------------------------------------------------------------
// core_list_lookup_if
//
// AXI4-Lite read-only channel bundle between the core list lookup engine
// (master) and the core list ROM (slave). There is no write channel.
//
// Signals:
//   AxiReadAddrValid_ValOut    master -> slave   AR valid
//   AxiReadAddrReady_RdyIn     slave  -> master  AR ready
//   AxiReadAddrAddress_AdrOut  master -> slave   AR byte address (word aligned)
//   AxiReadAddrProt_DatOut     master -> slave   AR protection, always 3'b000
//   AxiReadDataValid_ValIn     slave  -> master  R valid
//   AxiReadDataReady_RdyOut    master -> slave   R ready
//   AxiReadDataResponse_DatIn  slave  -> master  R response
//   AxiReadDataData_DatIn      slave  -> master  R data
// -----------------------------------------------------------------------------
interface core_list_lookup_if;
    logic        AxiReadAddrValid_ValOut;
    logic        AxiReadAddrReady_RdyIn;
    logic [15:0] AxiReadAddrAddress_AdrOut;
    logic [2:0]  AxiReadAddrProt_DatOut;
    logic        AxiReadDataValid_ValIn;
    logic        AxiReadDataReady_RdyOut;
    logic [1:0]  AxiReadDataResponse_DatIn;
    logic [31:0] AxiReadDataData_DatIn;

    modport master (
        output AxiReadAddrValid_ValOut,
        input  AxiReadAddrReady_RdyIn,
        output AxiReadAddrAddress_AdrOut,
        output AxiReadAddrProt_DatOut,
        input  AxiReadDataValid_ValIn,
        output AxiReadDataReady_RdyOut,
        input  AxiReadDataResponse_DatIn,
        input  AxiReadDataData_DatIn
    );

    modport slave (
        input  AxiReadAddrValid_ValOut,
        output AxiReadAddrReady_RdyIn,
        input  AxiReadAddrAddress_AdrOut,
        input  AxiReadAddrProt_DatOut,
        output AxiReadDataValid_ValIn,
        input  AxiReadDataReady_RdyOut,
        output AxiReadDataResponse_DatIn,
        output AxiReadDataData_DatIn
    );
endinterface

// File: rtl/core_list_lookup.sv
// -----------------------------------------------------------------------------
// core_list_lookup
//
// AXI4-Lite read master that walks the core list ROM entry by entry looking
// for a requested (CoreTypeNr, CoreInstNr) pair. When found, the entry's
// Version, AddressRangeLow, AddressRangeHigh and InterruptMask words are
// returned. One read is outstanding at a time.
//
// Entry layout (byte offsets inside an entry):
//   0x00 CoreTypeNr (0 terminates the list)   0x04 CoreInstNr
//   0x08 Version   0x0C AddrLow   0x10 AddrHigh   0x14 IrqMask
//
// Ports:
//   SysClk_ClkIn            system clock
//   SysRstN_RstIn           asynchronous active-low reset
//   LookupStart_ValIn       start pulse, honoured only while idle
//   LookupCoreType_DatIn    requested CoreTypeNr, latched at start
//   LookupCoreInst_DatIn    requested CoreInstNr, latched at start
//   LookupBusy_ValOut       high from the cycle after start through Done
//   LookupDone_ValOut       one-cycle completion pulse
//   LookupFound_DatOut      match found (valid from Done to next start)
//   LookupError_DatOut      a non-OKAY read response terminated the walk
//   LookupVersion_DatOut    entry word 0x08
//   LookupAddrLow_DatOut    entry word 0x0C
//   LookupAddrHigh_DatOut   entry word 0x10
//   LookupIrqMask_DatOut    entry word 0x14
//   Axi                     AXI4-Lite read channel (master side)
// -----------------------------------------------------------------------------
module core_list_lookup #(
    parameter int unsigned EntryBytes_Con = 64,
    parameter int unsigned MaxEntries_Con = 4096,
    parameter logic [15:0] BaseAddr_Con   = 16'h0000
) (
    input  logic                      SysClk_ClkIn,
    input  logic                      SysRstN_RstIn,
    input  logic                      LookupStart_ValIn,
    input  logic [31:0]               LookupCoreType_DatIn,
    input  logic [31:0]               LookupCoreInst_DatIn,
    output logic                      LookupBusy_ValOut,
    output logic                      LookupDone_ValOut,
    output logic                      LookupFound_DatOut,
    output logic                      LookupError_DatOut,
    output logic [31:0]               LookupVersion_DatOut,
    output logic [31:0]               LookupAddrLow_DatOut,
    output logic [31:0]               LookupAddrHigh_DatOut,
    output logic [31:0]               LookupIrqMask_DatOut,
    core_list_lookup_if.master        Axi
);

    // Index must be able to hold MaxEntries_Con itself, which is the value
    // that ends an unterminated walk.
    localparam int unsigned IdxW     = $clog2(MaxEntries_Con + 1);
    localparam int unsigned StrideSh = $clog2(EntryBytes_Con);

    localparam logic [4:0] OffType = 5'h00;
    localparam logic [4:0] OffInst = 5'h04;
    localparam logic [4:0] OffVer  = 5'h08;
    localparam logic [4:0] OffLow  = 5'h0C;
    localparam logic [4:0] OffHigh = 5'h10;
    localparam logic [4:0] OffIrq  = 5'h14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_EVAL,
        ST_DONE
    } state_t;

    state_t            state_q;
    logic [IdxW-1:0]   index_q;
    logic [4:0]        offset_q;
    logic [31:0]       type_q;
    logic [31:0]       inst_q;
    logic [31:0]       rdata_q;
    logic [1:0]        rresp_q;

    logic              busy_q;
    logic              done_q;
    logic              found_q;
    logic              error_q;
    logic [31:0]       version_q;
    logic [31:0]       addr_low_q;
    logic [31:0]       addr_high_q;
    logic [31:0]       irq_mask_q;

    logic              arvalid_q;
    logic [15:0]       araddr_q;
    logic              rready_q;

    logic [IdxW-1:0]   index_inc;
    logic              word_mismatch;

    // Byte address of a word; 16-bit arithmetic, wraps silently.
    function automatic logic [15:0] entry_addr(input logic [IdxW-1:0] idx,
                                               input logic [4:0]      off);
        return BaseAddr_Con + 16'(32'(idx) << StrideSh) + 16'(off);
    endfunction

    assign index_inc = index_q + IdxW'(1);

    // A header word that does not match the request moves on to the next entry.
    assign word_mismatch = ((offset_q == OffType) && (rdata_q != type_q)) ||
                           ((offset_q == OffInst) && (rdata_q != inst_q));

    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            offset_q    <= '0;
            type_q      <= '0;
            inst_q      <= '0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            error_q     <= 1'b0;
            version_q   <= '0;
            addr_low_q  <= '0;
            addr_high_q <= '0;
            irq_mask_q  <= '0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            rready_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (LookupStart_ValIn) begin
                        type_q      <= LookupCoreType_DatIn;
                        inst_q      <= LookupCoreInst_DatIn;
                        found_q     <= 1'b0;
                        error_q     <= 1'b0;
                        version_q   <= '0;
                        addr_low_q  <= '0;
                        addr_high_q <= '0;
                        irq_mask_q  <= '0;
                        index_q     <= '0;
                        offset_q    <= OffType;
                        araddr_q    <= entry_addr('0, OffType);
                        arvalid_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    // Address and valid are held until the slave accepts.
                    if (arvalid_q && Axi.AxiReadAddrReady_RdyIn) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (Axi.AxiReadDataValid_ValIn && rready_q) begin
                        rdata_q  <= Axi.AxiReadDataData_DatIn;
                        rresp_q  <= Axi.AxiReadDataResponse_DatIn;
                        rready_q <= 1'b0;
                        state_q  <= ST_EVAL;
                    end
                end

                ST_EVAL: begin
                    if (rresp_q != 2'b00) begin
                        error_q <= 1'b1;
                        found_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if ((offset_q == OffType) && (rdata_q == 32'd0)) begin
                        // End-of-list marker: request not present.
                        found_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (word_mismatch) begin
                        index_q  <= index_inc;
                        offset_q <= OffType;
                        if (index_inc == IdxW'(MaxEntries_Con)) begin
                            found_q <= 1'b0;
                            error_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            araddr_q  <= entry_addr(index_inc, OffType);
                            arvalid_q <= 1'b1;
                            state_q   <= ST_ADDR;
                        end
                    end else if (offset_q == OffIrq) begin
                        irq_mask_q <= rdata_q;
                        found_q    <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        // Matched header word or payload word: store and read on.
                        case (offset_q)
                            OffVer:  version_q   <= rdata_q;
                            OffLow:  addr_low_q  <= rdata_q;
                            OffHigh: addr_high_q <= rdata_q;
                            default: ;
                        endcase
                        offset_q  <= offset_q + 5'd4;
                        araddr_q  <= entry_addr(index_q, offset_q + 5'd4);
                        arvalid_q <= 1'b1;
                        state_q   <= ST_ADDR;
                    end
                end

                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign LookupBusy_ValOut      = busy_q;
    assign LookupDone_ValOut      = done_q;
    assign LookupFound_DatOut     = found_q;
    assign LookupError_DatOut     = error_q;
    assign LookupVersion_DatOut   = version_q;
    assign LookupAddrLow_DatOut   = addr_low_q;
    assign LookupAddrHigh_DatOut  = addr_high_q;
    assign LookupIrqMask_DatOut   = irq_mask_q;

    assign Axi.AxiReadAddrValid_ValOut   = arvalid_q;
    assign Axi.AxiReadAddrAddress_AdrOut = araddr_q;
    assign Axi.AxiReadAddrProt_DatOut    = 3'b000;
    assign Axi.AxiReadDataReady_RdyOut   = rready_q;

endmodule

// File: tb/tb_core_list_lookup.sv
module tb_core_list_lookup;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_list_lookup_if bus0 ();
    core_list_lookup_if bus1 ();

    logic        start0, start1;
    logic [31:0] ltype, linst;
    logic        busy0, done0, found0, err0;
    logic [31:0] ver0, low0, high0, irq0;
    logic        busy1, done1, found1, err1;
    logic [31:0] ver1, low1, high1, irq1;

    core_list_lookup u_dut0 (
        .SysClk_ClkIn          (clk),
        .SysRstN_RstIn         (rst_n),
        .LookupStart_ValIn     (start0),
        .LookupCoreType_DatIn  (ltype),
        .LookupCoreInst_DatIn  (linst),
        .LookupBusy_ValOut     (busy0),
        .LookupDone_ValOut     (done0),
        .LookupFound_DatOut    (found0),
        .LookupError_DatOut    (err0),
        .LookupVersion_DatOut  (ver0),
        .LookupAddrLow_DatOut  (low0),
        .LookupAddrHigh_DatOut (high0),
        .LookupIrqMask_DatOut  (irq0),
        .Axi                   (bus0)
    );

    core_list_lookup #(.MaxEntries_Con(3)) u_dut1 (
        .SysClk_ClkIn          (clk),
        .SysRstN_RstIn         (rst_n),
        .LookupStart_ValIn     (start1),
        .LookupCoreType_DatIn  (ltype),
        .LookupCoreInst_DatIn  (linst),
        .LookupBusy_ValOut     (busy1),
        .LookupDone_ValOut     (done1),
        .LookupFound_DatOut    (found1),
        .LookupError_DatOut    (err1),
        .LookupVersion_DatOut  (ver1),
        .LookupAddrLow_DatOut  (low1),
        .LookupAddrHigh_DatOut (high1),
        .LookupIrqMask_DatOut  (irq1),
        .Axi                   (bus1)
    );

    // Shared ROM slave model; sel chooses which master it serves.
    logic        sel;
    logic        s_arready, s_rvalid;
    logic [1:0]  s_rresp;
    logic [31:0] s_rdata;
    int          ar_delay, r_delay, mem_mode;
    logic [15:0] err_addr;

    assign bus0.AxiReadAddrReady_RdyIn    = !sel && s_arready;
    assign bus0.AxiReadDataValid_ValIn    = !sel && s_rvalid;
    assign bus0.AxiReadDataResponse_DatIn = s_rresp;
    assign bus0.AxiReadDataData_DatIn     = s_rdata;
    assign bus1.AxiReadAddrReady_RdyIn    = sel && s_arready;
    assign bus1.AxiReadDataValid_ValIn    = sel && s_rvalid;
    assign bus1.AxiReadDataResponse_DatIn = s_rresp;
    assign bus1.AxiReadDataData_DatIn     = s_rdata;

    logic        m_arvalid, m_rready;
    logic [15:0] m_araddr;
    assign m_arvalid = sel ? bus1.AxiReadAddrValid_ValOut   : bus0.AxiReadAddrValid_ValOut;
    assign m_araddr  = sel ? bus1.AxiReadAddrAddress_AdrOut : bus0.AxiReadAddrAddress_AdrOut;
    assign m_rready  = sel ? bus1.AxiReadDataReady_RdyOut   : bus0.AxiReadDataReady_RdyOut;

    // ROM contents. Mode 0: entries (1,1), (2,1), (2,2,...), terminator.
    // Mode 1: every entry is (1,1), no terminator.
    function automatic logic [31:0] mem_word(input logic [15:0] a, input int md);
        int e;
        int o;
        e = int'(a) >> 6;
        o = int'(a) & 63;
        if (md == 1) return (o == 0 || o == 4) ? 32'd1 : 32'd0;
        case (e)
            0: return (o == 0 || o == 4) ? 32'd1 : 32'd0;
            1: return (o == 0) ? 32'd2 : (o == 4) ? 32'd1 : 32'd0;
            2: case (o)
                   0:  return 32'd2;
                   4:  return 32'd2;
                   8:  return 32'h0001_0000;
                   12: return 32'h0100_0000;
                   16: return 32'h0100_FFFF;
                   20: return 32'h0000_0004;
                   default: return 32'd0;
               endcase
            default: return 32'd0;
        endcase
    endfunction

    logic [15:0] ar_log [0:255];
    int          ar_n = 0;
    int          outst_err = 0;
    bit          pending = 0;
    logic [15:0] lat_addr;
    int          arcnt, rcnt;

    initial begin
        s_arready = 0; s_rvalid = 0; s_rresp = 0; s_rdata = 0;
        arcnt = 0; rcnt = 0; lat_addr = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                s_arready = 0; s_rvalid = 0; pending = 0; arcnt = 0; rcnt = 0;
            end else begin
                if (s_arready) begin
                    s_arready = 0;
                    if (pending) outst_err++;
                    if (ar_n < 256) ar_log[ar_n] = lat_addr;
                    ar_n++;
                    pending = 1;
                    rcnt = 0;
                end else if (m_arvalid) begin
                    if (arcnt >= ar_delay) begin
                        s_arready = 1; lat_addr = m_araddr; arcnt = 0;
                    end else arcnt++;
                end
                if (s_rvalid) begin
                    s_rvalid = 0; pending = 0;
                end else if (pending && m_rready) begin
                    if (rcnt >= r_delay) begin
                        s_rvalid = 1;
                        s_rdata  = mem_word(lat_addr, mem_mode);
                        s_rresp  = (lat_addr == err_addr) ? 2'b10 : 2'b00;
                        rcnt = 0;
                    end else rcnt++;
                end
            end
        end
    end

    // Protocol monitor, sampled on the falling edge.
    int          done_cnt = 0, stab_err = 0, rr_err = 0;
    logic        pv = 0, phs = 0;
    logic [15:0] pa = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv <= 0;
        end else begin
            if (pv && !phs && (!m_arvalid || m_araddr != pa)) stab_err <= stab_err + 1;
            if (m_rready && !pending) rr_err <= rr_err + 1;
            pv  <= m_arvalid;
            pa  <= m_araddr;
            phs <= m_arvalid && s_arready;
            if (sel ? done1 : done0) done_cnt <= done_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    logic [15:0] expq[$];

    task automatic check_ars(input string tag, input int base);
        check_val({tag, "_count"}, 32'(ar_n - base), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++)
            check_val($sformatf("%s_addr%0d", tag, i), 32'(ar_log[(base + i) % 256]), 32'(expq[i]));
    endtask

    task automatic check_res(input string tag, input logic f, input logic e,
                             input logic [31:0] v, input logic [31:0] l,
                             input logic [31:0] h, input logic [31:0] q);
        check_val({tag, "_found"}, 32'(found0), 32'(f));
        check_val({tag, "_error"}, 32'(err0), 32'(e));
        check_val({tag, "_ver"},   ver0,  v);
        check_val({tag, "_low"},   low0,  l);
        check_val({tag, "_high"},  high0, h);
        check_val({tag, "_irq"},   irq0,  q);
        check_val({tag, "_busy"},  32'(busy0), 32'd0);
    endtask

    task automatic run_lookup(input string tag, input logic [31:0] t, input logic [31:0] i,
                              input bit use1, input bit poke);
        int base_done;
        int cyc;
        base_done = done_cnt;
        @(negedge clk);
        ltype = t; linst = i;
        if (use1) start1 = 1; else start0 = 1;
        @(negedge clk);
        start0 = 0; start1 = 0;
        check_val({tag, "_busy_rise"}, 32'(use1 ? busy1 : busy0), 32'd1);
        cyc = 0;
        while (done_cnt == base_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (poke) begin
                // Starts while busy (including the Done cycle) must be ignored.
                start0 = busy0 && ((cyc % 7) == 3 || done0);
                ltype = 32'h1; linst = 32'h1;
            end
        end
        start0 = 0;
        repeat (4) @(negedge clk);
        check_val({tag, "_done_pulses"}, 32'(done_cnt - base_done), 32'd1);
    endtask

    int b;

    initial begin
        start0 = 0; start1 = 0; ltype = 0; linst = 0; sel = 0;
        ar_delay = 0; r_delay = 0; mem_mode = 0; err_addr = 16'hFFFF;
        rst_n = 0;
        repeat (3) @(negedge clk);

        check_val("rst_busy",    32'(busy0), 32'd0);
        check_val("rst_done",    32'(done0), 32'd0);
        check_val("rst_found",   32'(found0), 32'd0);
        check_val("rst_error",   32'(err0), 32'd0);
        check_val("rst_ver",     ver0, 32'd0);
        check_val("rst_irq",     irq0, 32'd0);
        check_val("rst_arvalid", 32'(bus0.AxiReadAddrValid_ValOut), 32'd0);
        check_val("rst_araddr",  32'(bus0.AxiReadAddrAddress_AdrOut), 32'd0);
        check_val("rst_rready",  32'(bus0.AxiReadDataReady_RdyOut), 32'd0);
        check_val("rst_prot",    32'(bus0.AxiReadAddrProt_DatOut), 32'd0);

        rst_n = 1;
        @(negedge clk);

        // Hit on entry 2
        b = ar_n;
        run_lookup("t1", 32'd2, 32'd2, 0, 0);
        expq = '{16'h00, 16'h40, 16'h44, 16'h80, 16'h84, 16'h88, 16'h8C, 16'h90, 16'h94};
        check_ars("t1_ar", b);
        check_res("t1", 1'b1, 1'b0, 32'h0001_0000, 32'h0100_0000, 32'h0100_FFFF, 32'h4);

        // Miss, terminated by entry 3
        b = ar_n;
        run_lookup("t2", 32'd5, 32'd0, 0, 0);
        expq = '{16'h00, 16'h40, 16'h80, 16'hC0};
        check_ars("t2_ar", b);
        check_res("t2", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

        // SLVERR on the instance word of entry 1
        err_addr = 16'h0044;
        b = ar_n;
        run_lookup("t3", 32'd2, 32'd2, 0, 0);
        expq = '{16'h00, 16'h40, 16'h44};
        check_ars("t3_ar", b);
        check_res("t3", 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
        err_addr = 16'hFFFF;

        // Slow slave and start pulses while busy
        ar_delay = 10; r_delay = 7;
        b = ar_n;
        run_lookup("t4", 32'd2, 32'd2, 0, 1);
        expq = '{16'h00, 16'h40, 16'h44, 16'h80, 16'h84, 16'h88, 16'h8C, 16'h90, 16'h94};
        check_ars("t4_ar", b);
        check_res("t4", 1'b1, 1'b0, 32'h0001_0000, 32'h0100_0000, 32'h0100_FFFF, 32'h4);
        check_val("t4_ar_stable",   32'(stab_err), 32'd0);
        check_val("t4_rready_data", 32'(rr_err), 32'd0);
        check_val("t4_outstanding", 32'(outst_err), 32'd0);

        // Reset during the Data phase of the second read
        ar_delay = 0; r_delay = 30;
        @(negedge clk);
        ltype = 32'd2; linst = 32'd2; start0 = 1;
        @(negedge clk);
        start0 = 0;
        for (int c = 0; c < 200; c++) begin
            if (bus0.AxiReadDataReady_RdyOut && bus0.AxiReadAddrAddress_AdrOut == 16'h0040) break;
            @(negedge clk);
        end
        check_val("t5_in_data",  32'(bus0.AxiReadDataReady_RdyOut), 32'd1);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        check_val("t5_rst_rready",  32'(bus0.AxiReadDataReady_RdyOut), 32'd0);
        check_val("t5_rst_arvalid", 32'(bus0.AxiReadAddrValid_ValOut), 32'd0);
        check_val("t5_rst_araddr",  32'(bus0.AxiReadAddrAddress_AdrOut), 32'd0);
        check_val("t5_rst_busy",    32'(busy0), 32'd0);
        check_val("t5_rst_done",    32'(done0), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        r_delay = 0;
        @(negedge clk);
        b = ar_n;
        run_lookup("t5", 32'd2, 32'd2, 0, 0);
        expq = '{16'h00, 16'h40, 16'h44, 16'h80, 16'h84, 16'h88, 16'h8C, 16'h90, 16'h94};
        check_ars("t5_ar", b);
        check_res("t5", 1'b1, 1'b0, 32'h0001_0000, 32'h0100_0000, 32'h0100_FFFF, 32'h4);

        // Entry limit of 3 on an unterminated list
        sel = 1; mem_mode = 1;
        @(negedge clk);
        b = ar_n;
        run_lookup("t6", 32'd9, 32'd9, 1, 0);
        expq = '{16'h00, 16'h40, 16'h80};
        check_ars("t6_ar", b);
        check_val("t6_found", 32'(found1), 32'd0);
        check_val("t6_error", 32'(err1), 32'd0);
        check_val("t6_busy",  32'(busy1), 32'd0);
        check_val("t6_ver",   ver1 | low1 | high1 | irq1, 32'd0);

        check_val("all_ar_stable",   32'(stab_err), 32'd0);
        check_val("all_rready_data", 32'(rr_err), 32'd0);
        check_val("all_outstanding", 32'(outst_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
